// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl_pkg
//  Purpose  : Shared constants for the interrupt controller.
//             - register indices
//             - bus address and data widths
//             - default channel count
//  Revision : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    // Default channel count. It matches the CPU interrupt input width.
    localparam int CPU_IRQ_CH_DEF = 8;

    localparam int IRQ_ADDR_W = 2;
    localparam int IRQ_DATA_W = 32;

    typedef logic [IRQ_ADDR_W-1:0] irq_addr_t;

    localparam irq_addr_t IRQ_ADDR_PEND = 2'd0;  // R, write-1-to-clear
    localparam irq_addr_t IRQ_ADDR_EN   = 2'd1;  // R/W enable mask
    localparam irq_addr_t IRQ_ADDR_MODE = 2'd2;  // R/W, 1 = rising edge, 0 = level
    localparam irq_addr_t IRQ_ADDR_RAW  = 2'd3;  // R, synchronized sources

endpackage : irq_ctrl_pkg
`default_nettype wire

// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl_if
//  Purpose  : Register bus between the CPU and the interrupt controller.
//             The select, strobe and acknowledge signals are active low.
//  Signals  : cs_, as_, rw (1 = read), addr, wr_data  (master -> slave)
//             rd_data, rdy_                            (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic                  cs_;
    logic                  as_;
    logic                  rw;
    logic [IRQ_ADDR_W-1:0] addr;
    logic [IRQ_DATA_W-1:0] wr_data;
    logic [IRQ_DATA_W-1:0] rd_data;
    logic                  rdy_;

    modport master (
        output cs_, as_, rw, addr, wr_data,
        input  rd_data, rdy_
    );

    modport slave (
        input  cs_, as_, rw, addr, wr_data,
        output rd_data, rdy_
    );

endinterface : irq_ctrl_if
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
//  Module   : irq_sync
//  Purpose  : Synchronizer and rising-edge detector for one interrupt channel.
//             A 2-flop synchronizer feeds a third, delayed flop.
//  Ports    : clk, reset (async, active high)
//             i_src   raw asynchronous source
//             o_sync  synchronized source
//             o_rise  one-cycle pulse on a synchronized rising edge
//  Revision : 1.0 - initial release
// ============================================================================
module irq_sync (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_src,
    output logic      o_sync,
    output logic      o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_src;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_dly;

endmodule : irq_sync
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : Interrupt controller.
//             - a pending register that latches edges or follows levels
//             - an enable mask
//             - a registered irq output equal to PEND & EN
//  Ports    : clk, reset (async, active high)
//             bus   register bus (slave); access = cs_ & as_ both low,
//                   one-cycle rdy_ acknowledge on the following cycle
//             src   raw asynchronous interrupt sources
//             irq   registered interrupt requests to the CPU
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int CPU_IRQ_CH = CPU_IRQ_CH_DEF    // must not exceed IRQ_DATA_W
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    irq_ctrl_if.slave                  bus,
    input  wire logic [CPU_IRQ_CH-1:0] src,
    output logic      [CPU_IRQ_CH-1:0] irq
);

    logic [CPU_IRQ_CH-1:0] w_sync;
    logic [CPU_IRQ_CH-1:0] w_rise;
    logic [CPU_IRQ_CH-1:0] r_pend;
    logic [CPU_IRQ_CH-1:0] r_en;
    logic [CPU_IRQ_CH-1:0] r_mode;
    logic [CPU_IRQ_CH-1:0] r_irq;
    logic [IRQ_DATA_W-1:0] r_rd_data;
    logic                  r_rdy_n;

    logic                  w_access;
    logic                  w_write;
    logic                  w_read;
    logic                  w_mode_wr;
    logic [CPU_IRQ_CH-1:0] w_wr_bits;
    logic [CPU_IRQ_CH-1:0] w_w1c;
    logic [CPU_IRQ_CH-1:0] w_to_edge;
    logic [CPU_IRQ_CH-1:0] w_pend_edge;
    logic [CPU_IRQ_CH-1:0] w_pend_next;
    logic [IRQ_DATA_W-1:0] w_rd_mux;
    logic                  w_unused_wr;

    genvar gi;
    generate
        for (gi = 0; gi < CPU_IRQ_CH; gi++) begin : g_sync
            irq_sync u_sync (
                .clk    (clk),
                .reset  (reset),
                .i_src  (src[gi]),
                .o_sync (w_sync[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    assign w_access  = ~bus.cs_ & ~bus.as_;
    assign w_write   = w_access & ~bus.rw;
    assign w_read    = w_access &  bus.rw;
    assign w_wr_bits = bus.wr_data[CPU_IRQ_CH-1:0];
    // Write data bits above the channel count are ignored.
    assign w_unused_wr = ^bus.wr_data;

    assign w_mode_wr = w_write && (bus.addr == IRQ_ADDR_MODE);
    assign w_w1c     = (w_write && (bus.addr == IRQ_ADDR_PEND)) ? w_wr_bits : '0;

    // Bits switching from level to edge lose the pending state they had while
    // in level mode. Otherwise a source that is held high would look like a
    // fresh edge. A real edge in that same cycle is still kept.
    assign w_to_edge = w_mode_wr ? (~r_mode & w_wr_bits) : '0;

    // Edge channels are sticky. Clearing is done with W1C, and a new edge in
    // the same cycle wins. Level channels follow the synchronized source.
    assign w_pend_edge = (r_pend & ~w_w1c) | w_rise;
    assign w_pend_next = (((r_mode & w_pend_edge) | (~r_mode & w_sync)) & ~w_to_edge)
                       | (w_to_edge & w_rise);

    always_comb begin
        w_rd_mux = '0;
        case (bus.addr)
            IRQ_ADDR_PEND: w_rd_mux[CPU_IRQ_CH-1:0] = r_pend;
            IRQ_ADDR_EN:   w_rd_mux[CPU_IRQ_CH-1:0] = r_en;
            IRQ_ADDR_MODE: w_rd_mux[CPU_IRQ_CH-1:0] = r_mode;
            IRQ_ADDR_RAW:  w_rd_mux[CPU_IRQ_CH-1:0] = w_sync;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend    <= '0;
            r_en      <= '0;
            r_mode    <= '0;
            r_irq     <= '0;
            r_rd_data <= '0;
            r_rdy_n   <= 1'b1;
        end else begin
            r_pend <= w_pend_next;
            if (w_write && (bus.addr == IRQ_ADDR_EN)) begin
                r_en <= w_wr_bits;
            end
            if (w_mode_wr) begin
                r_mode <= w_wr_bits;
            end
            r_irq     <= r_pend & r_en;
            r_rdy_n   <= ~w_access;
            r_rd_data <= w_read ? w_rd_mux : '0;
        end
    end

    assign irq         = r_irq;
    assign bus.rd_data = r_rd_data;
    assign bus.rdy_    = r_rdy_n;

endmodule : irq_ctrl
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl
//  Purpose  : Directed, self-checking bench for irq_ctrl (8 channels).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] src;
    logic [7:0] irq;
    int         n_cmp;
    int         n_err;
    logic [31:0] rd;

    irq_ctrl_if bus_if ();

    irq_ctrl #(.CPU_IRQ_CH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .src   (src),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Wait n clock edges, then move 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.cs_     = 1'b1;
        bus_if.as_     = 1'b1;
        bus_if.rw      = 1'b1;
        bus_if.addr    = '0;
        bus_if.wr_data = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.cs_ = 1'b0; bus_if.as_ = 1'b0; bus_if.rw = 1'b0;
        bus_if.addr = a; bus_if.wr_data = d;
        step(1);
        bus_idle();
        check("wr_rdy", {31'd0, bus_if.rdy_}, 32'd0);
        check("wr_rdata", bus_if.rd_data, 32'd0);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_if.cs_ = 1'b0; bus_if.as_ = 1'b0; bus_if.rw = 1'b1;
        bus_if.addr = a; bus_if.wr_data = '0;
        step(1);
        bus_idle();
        check("rd_rdy", {31'd0, bus_if.rdy_}, 32'd0);
        d = bus_if.rd_data;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        src   = 8'h00;
        bus_idle();

        // ---------------- reset state
        step(2);
        check("rst_irq", {24'd0, irq}, 32'd0);
        check("rst_rdy", {31'd0, bus_if.rdy_}, 32'd1);
        check("rst_rdata", bus_if.rd_data, 32'd0);
        reset = 1'b0;
        step(1);
        bus_read(IRQ_ADDR_PEND, rd); check("rst_pend", rd, 32'd0);
        bus_read(IRQ_ADDR_EN,   rd); check("rst_en",   rd, 32'd0);
        bus_read(IRQ_ADDR_MODE, rd); check("rst_mode", rd, 32'd0);

        // ---------------- RAW read handshake, src = 0xA5
        src = 8'hA5;
        step(3);
        bus_read(IRQ_ADDR_RAW, rd);
        check("raw_rdata", rd, 32'h0000_00A5);
        step(1);
        check("raw_rdy_after", {31'd0, bus_if.rdy_}, 32'd1);
        check("raw_rdata_after", bus_if.rd_data, 32'd0);
        bus_read(IRQ_ADDR_PEND, rd); check("lvl_pend_a5", rd, 32'h0000_00A5);
        check("lvl_irq_masked", {24'd0, irq}, 32'd0);
        src = 8'h00;
        step(3);

        // ---------------- level mode with mask
        src = 8'h08;
        step(3);
        bus_read(IRQ_ADDR_PEND, rd); check("lvl_pend_08", rd, 32'h08);
        check("lvl_irq_0", {24'd0, irq}, 32'd0);
        bus_write(IRQ_ADDR_EN, 32'h08);
        check("lvl_irq_still0", {24'd0, irq}, 32'd0);
        step(1);
        check("lvl_irq_08", {24'd0, irq}, 32'h08);
        bus_write(IRQ_ADDR_PEND, 32'h08);
        bus_read(IRQ_ADDR_PEND, rd); check("lvl_w1c_noeffect", rd, 32'h08);
        check("lvl_irq_hold", {24'd0, irq}, 32'h08);
        src = 8'h00;
        bus_write(IRQ_ADDR_EN, 32'h00);
        step(3);
        bus_read(IRQ_ADDR_PEND, rd); check("lvl_pend_fall", rd, 32'h00);

        // ---------------- edge latency
        bus_write(IRQ_ADDR_MODE, 32'h01);
        bus_write(IRQ_ADDR_EN,   32'h01);
        src = 8'h01;
        step(1);
        src = 8'h00;
        check("edge_lat_c1", {24'd0, irq}, 32'd0);
        step(1); check("edge_lat_c2", {24'd0, irq}, 32'd0);
        step(1); check("edge_lat_c3", {24'd0, irq}, 32'd0);
        step(1); check("edge_lat_c4", {24'd0, irq}, 32'h01);
        step(5); check("edge_hold", {24'd0, irq}, 32'h01);
        bus_read(IRQ_ADDR_PEND, rd); check("edge_pend", rd, 32'h01);

        // ---------------- W1C on edge bit, then set/clear collision
        bus_write(IRQ_ADDR_PEND, 32'h01);
        bus_read(IRQ_ADDR_PEND, rd); check("edge_w1c", rd, 32'h00);
        check("edge_irq_drop", {24'd0, irq}, 32'h00);
        src = 8'h01;
        step(1);
        src = 8'h00;
        step(1);
        bus_write(IRQ_ADDR_PEND, 32'h01);   // same edge that sets PEND[0]
        bus_read(IRQ_ADDR_PEND, rd); check("collision_set_wins", rd, 32'h01);

        // ---------------- W1C clear of one bit out of 0x05
        bus_write(IRQ_ADDR_MODE, 32'h05);
        bus_write(IRQ_ADDR_EN,   32'h05);
        src = 8'h04;
        step(1);
        src = 8'h00;
        step(4);
        bus_read(IRQ_ADDR_PEND, rd); check("pend_05", rd, 32'h05);
        check("irq_05", {24'd0, irq}, 32'h05);
        bus_write(IRQ_ADDR_PEND, 32'h04);
        step(1);
        check("irq_01_after_w1c", {24'd0, irq}, 32'h01);
        bus_read(IRQ_ADDR_PEND, rd); check("pend_01", rd, 32'h01);

        // ---------------- level -> edge switch drops stale level state
        src = 8'h08;
        step(3);
        bus_read(IRQ_ADDR_PEND, rd); check("pend_lvl3", rd, 32'h09);
        bus_write(IRQ_ADDR_MODE, 32'h0D);
        step(2);
        bus_read(IRQ_ADDR_PEND, rd); check("mode_switch_clear", rd, 32'h01);
        src = 8'h00;

        // ---------------- register width and readback
        bus_read(IRQ_ADDR_EN, rd); check("en_readback", rd, 32'h05);
        bus_write(IRQ_ADDR_EN, 32'hFFFF_FFFF);
        bus_read(IRQ_ADDR_EN, rd); check("en_upper_zero", rd, 32'h0000_00FF);
        bus_read(IRQ_ADDR_MODE, rd); check("mode_readback", rd, 32'h0D);

        // ---------------- reset mid-operation (level mode, EN = 0xFF)
        bus_write(IRQ_ADDR_MODE, 32'h00);
        src = 8'h01;
        step(4);
        check("pre_rst_irq", {24'd0, irq}, 32'h01);
        reset = 1'b1;
        #1;
        check("mid_rst_irq", {24'd0, irq}, 32'd0);
        // access presented while reset is held gets no acknowledge
        bus_if.cs_ = 1'b0; bus_if.as_ = 1'b0; bus_if.rw = 1'b0;
        bus_if.addr = IRQ_ADDR_MODE; bus_if.wr_data = 32'hFF;
        step(1);
        check("rst_abort_rdy", {31'd0, bus_if.rdy_}, 32'd1);
        bus_idle();
        src = 8'h00;
        step(1);
        reset = 1'b0;
        step(1);
        bus_read(IRQ_ADDR_PEND, rd); check("post_rst_pend", rd, 32'd0);
        bus_read(IRQ_ADDR_EN,   rd); check("post_rst_en",   rd, 32'd0);
        bus_read(IRQ_ADDR_MODE, rd); check("post_rst_mode", rd, 32'd0);
        bus_read(IRQ_ADDR_RAW,  rd); check("post_rst_raw",  rd, 32'd0);
        check("post_rst_irq", {24'd0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_irq_ctrl
`default_nettype wire
